tile_readout: RTL

Downstream consumer of the 4x16 multiply-accumulate tile's 64 lane outputs (lane = row*NUM_COLS + col). On a start pulse it snapshots all lanes and streams them one per transfer over a valid/ready interface. It also produces the running total of all lanes and a done pulse. The block drives the tile's top-level result path so the accumulator grid can keep running while results drain.

---
 rtl/tile_pkg.sv | 20 ++
 rtl/tile_readout_acc.sv | 78 +++++++
 rtl/tile_readout.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tile_pkg.sv
// Shared types and sizing for the 4x16 MAC tile readout path.
package tile_pkg;

  localparam int NUM_ROWS  = 4;
  localparam int NUM_COLS  = 16;
  localparam int NUM_LANES = NUM_ROWS * NUM_COLS;
  localparam int DATA_W    = 32;
  localparam int LANE_W    = $clog2(NUM_LANES);
  // One extra bit per doubling of lanes, so the full-scale sum never wraps.
  localparam int SUM_W     = DATA_W + LANE_W;

  typedef logic [DATA_W-1:0] lane_val_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } readout_state_e;

endpackage

// File: rtl/tile_readout_acc.sv
// Running sum of streamed lanes, committed to o_total on the last transfer.
// With TILE_READOUT_MAX_EN defined, also tracks the largest unsigned lane
// value (lowest index on ties) and commits it alongside the total.
module tile_readout_acc
  import tile_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_xfer,
  input  logic              i_last,
  input  lane_val_t         i_data,
`ifdef TILE_READOUT_MAX_EN
  input  logic [LANE_W-1:0] i_lane,
  output lane_val_t         o_max,
  output logic [LANE_W-1:0] o_max_lane,
`endif
  output logic [SUM_W-1:0]  o_total
);

  logic [SUM_W-1:0] r_acc;
  logic [SUM_W-1:0] r_total;
  logic [SUM_W-1:0] w_sum;

  assign w_sum   = r_acc + SUM_W'(i_data);
  assign o_total = r_total;

  // Accumulate each transfer; the final transfer's sum becomes the visible total.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc   <= '0;
      r_total <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_xfer) begin
      r_acc <= w_sum;
      if (i_last) r_total <= w_sum;
    end
  end

`ifdef TILE_READOUT_MAX_EN
  lane_val_t         r_run_max;
  logic [LANE_W-1:0] r_run_lane;
  lane_val_t         r_max;
  logic [LANE_W-1:0] r_max_lane;
  logic              w_take;
  lane_val_t         w_max_nxt;
  logic [LANE_W-1:0] w_lane_nxt;

  // Strict compare keeps the earlier (lower) index when values tie.
  assign w_take     = i_data > r_run_max;
  assign w_max_nxt  = w_take ? i_data : r_run_max;
  assign w_lane_nxt = w_take ? i_lane : r_run_lane;
  assign o_max      = r_max;
  assign o_max_lane = r_max_lane;

  // Track the running maximum and publish it on the last transfer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_run_max  <= '0;
      r_run_lane <= '0;
      r_max      <= '0;
      r_max_lane <= '0;
    end else if (i_clear) begin
      r_run_max  <= '0;
      r_run_lane <= '0;
    end else if (i_xfer) begin
      r_run_max  <= w_max_nxt;
      r_run_lane <= w_lane_nxt;
      if (i_last) begin
        r_max      <= w_max_nxt;
        r_max_lane <= w_lane_nxt;
      end
    end
  end
`endif

endmodule

// File: rtl/tile_readout.sv
// Snapshots the MAC tile's 64 lane outputs on i_start and streams them one
// per valid/ready transfer, lane 0 first, then pulses o_done and publishes
// the lane total. Optional feature macro: TILE_READOUT_MAX_EN adds o_max and
// o_max_lane (largest lane value of the readout and its index).
module tile_readout
  import tile_pkg::*;
(
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [NUM_LANES-1:0][DATA_W-1:0] i_lane_val,
  input  logic                            i_start,
  input  logic                            i_abort,
  output logic                            o_busy,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [DATA_W-1:0]               o_data,
  output logic [LANE_W-1:0]               o_lane,
  output logic                            o_done,
`ifdef TILE_READOUT_MAX_EN
  output logic [DATA_W-1:0]               o_max,
  output logic [LANE_W-1:0]               o_max_lane,
`endif
  output logic [SUM_W-1:0]                o_total
);

  readout_state_e    r_state;
  lane_val_t         r_snap [NUM_LANES];
  logic [LANE_W-1:0] r_idx;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  logic w_accept;
  logic w_xfer;
  logic w_last;
  logic w_clear;

  // A start is only honoured from IDLE, and abort always overrides it.
  assign w_accept = (r_state == IDLE) && i_start && !i_abort;
  assign w_xfer   = (r_state == STREAM) && r_valid && i_ready && !i_abort;
  assign w_last   = (r_idx == LANE_W'(NUM_LANES - 1));
  assign w_clear  = w_accept || i_abort;

  assign o_valid = r_valid;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_lane  = r_idx;
  assign o_data  = r_snap[r_idx];

  // Freeze the tile outputs so the grid can keep accumulating while we drain.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_LANES; k++) r_snap[k] <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < NUM_LANES; k++) r_snap[k] <= i_lane_val[k];
    end
  end

  // Readout sequencer with registered handshake/status outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state <= STREAM;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        STREAM: begin
          if (i_abort) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_xfer) begin
            if (w_last) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + LANE_W'(1);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  tile_readout_acc u_acc (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (w_clear),
    .i_xfer     (w_xfer),
    .i_last     (w_last),
    .i_data     (o_data),
`ifdef TILE_READOUT_MAX_EN
    .i_lane     (r_idx),
    .o_max      (o_max),
    .o_max_lane (o_max_lane),
`endif
    .o_total    (o_total)
  );

endmodule
